// File: rtl/y86_pkg.sv
// Shared Y86-64 encoding constants, the decoded-instruction record and the
// instruction-length helpers used by both the encoder and the fetch stage.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] R_RAX  = 4'h0;
    localparam logic [3:0] R_RCX  = 4'h1;
    localparam logic [3:0] R_RDX  = 4'h2;
    localparam logic [3:0] R_RBX  = 4'h3;
    localparam logic [3:0] R_RSP  = 4'h4;
    localparam logic [3:0] R_RBP  = 4'h5;
    localparam logic [3:0] R_RSI  = 4'h6;
    localparam logic [3:0] R_RDI  = 4'h7;
    localparam logic [3:0] R_R8   = 4'h8;
    localparam logic [3:0] R_R9   = 4'h9;
    localparam logic [3:0] R_R10  = 4'hA;
    localparam logic [3:0] R_R11  = 4'hB;
    localparam logic [3:0] R_R12  = 4'hC;
    localparam logic [3:0] R_R13  = 4'hD;
    localparam logic [3:0] R_R14  = 4'hE;
    localparam logic [3:0] R_NONE = 4'hF;

    localparam int MAX_LEN = 10;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
    } instr_t;

    // Encoded length in bytes; zero marks an illegal icode.
    function automatic logic [3:0] ilen(input logic [3:0] icode);
        case (icode)
            I_HALT, I_NOP, I_RET:                    return 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:        return 4'd2;
            I_JXX, I_CALL:                           return 4'd9;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:            return 4'd10;
            default:                                 return 4'd0;
        endcase
    endfunction

    function automatic logic has_regb(input logic [3:0] icode);
        case (icode)
            I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_OPQ, I_PUSHQ, I_POPQ:                  return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/y86_byte_sel.sv
// Picks encoded byte number idx of an instruction: opcode byte, optional
// register byte, then valC least-significant byte first.
module y86_byte_sel
    import y86_pkg::*;
(
    input  instr_t     fields,
    input  logic       reg_byte,
    input  logic [3:0] idx,
    output logic [7:0] byte_out
);

    logic [3:0] c_idx;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        byte_out = 8'h00;
        c_idx    = 4'd0;
        if (idx == 4'd0) begin
            byte_out = {fields.icode, fields.ifun};
        end else if (reg_byte && idx == 4'd1) begin
            byte_out = {fields.ra, fields.rb};
        end else begin
            c_idx = reg_byte ? idx - 4'd2 : idx - 4'd1;
            if (c_idx < 4'd8)
                byte_out = fields.valc[{c_idx[2:0], 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/y86_instr_encoder.sv
// Serialising Y86-64 instruction encoder: one decoded instruction in, its
// byte stream out to instruction memory. Optional feature: Y86_ENC_HALT_LOCK_EN.
module y86_instr_encoder
    import y86_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [63:0]       valC,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] next_pc,
    output logic              busy,
    output logic              err
);

`ifdef Y86_ENC_HALT_LOCK_EN
    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_LOCKED} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_EMIT} state_t;
`endif

    state_t      state;
    instr_t      fields;
    logic        reg_byte;
    logic [3:0]  len;
    logic [3:0]  idx;

    instr_t      in_fields;
    logic [3:0]  in_len;
    logic        in_legal;
    logic        accept;
    logic        last;
    logic [ADDR_W-1:0] base_pc;

    instr_t      sel_fields;
    logic        sel_reg;
    logic [3:0]  sel_idx;
    logic [7:0]  sel_byte;

    assign in_fields = {icode, ifun, rA, rB, valC};
    assign in_len    = ilen(icode);
    assign in_legal  = (in_len != 4'd0);
    assign in_ready  = (state == S_IDLE);
    assign busy      = (state == S_EMIT);
    assign accept    = in_valid && in_ready;
    assign last      = (idx == len - 4'd1);
    // A start in the accept cycle takes effect before the instruction is placed.
    assign base_pc   = start ? base_addr : next_pc;

    // In IDLE the selector looks at the incoming fields to pre-load byte 0;
    // in EMIT it looks ahead one byte so wr_data is ready at the next edge.
    assign sel_fields = (state == S_IDLE) ? in_fields : fields;
    assign sel_reg    = (state == S_IDLE) ? has_regb(icode) : reg_byte;
    assign sel_idx    = (state == S_IDLE) ? 4'd0 : idx + 4'd1;

    y86_byte_sel u_byte_sel (
        .fields   (sel_fields),
        .reg_byte (sel_reg),
        .idx      (sel_idx),
        .byte_out (sel_byte)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            fields   <= '0;
            reg_byte <= 1'b0;
            len      <= 4'd0;
            idx      <= 4'd0;
            next_pc  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'h00;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start)
                        next_pc <= base_addr;
                    if (accept) begin
                        if (in_legal) begin
                            fields   <= in_fields;
                            reg_byte <= has_regb(icode);
                            len      <= in_len;
                            idx      <= 4'd0;
                            wr_en    <= 1'b1;
                            wr_addr  <= base_pc;
                            wr_data  <= sel_byte;
                            state    <= S_EMIT;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (wr_ready) begin
                        if (last) begin
                            wr_en   <= 1'b0;
                            next_pc <= next_pc + ADDR_W'(len);
`ifdef Y86_ENC_HALT_LOCK_EN
                            state   <= (fields.icode == I_HALT) ? S_LOCKED : S_IDLE;
`else
                            state   <= S_IDLE;
`endif
                        end else begin
                            idx     <= sel_idx;
                            wr_addr <= next_pc + ADDR_W'(sel_idx);
                            wr_data <= sel_byte;
                        end
                    end
                end
`ifdef Y86_ENC_HALT_LOCK_EN
                S_LOCKED: begin
                    if (start) begin
                        next_pc <= base_addr;
                        state   <= S_IDLE;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
